// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined LEGv8 immediate generator.
// Decodes a 32-bit instruction word (D, CB, B and I formats) into an N-bit
// extended immediate and a 3-bit format code. Results go into a DEPTH-entry
// circular queue with valid/ready handshakes on both sides.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   flush      synchronous queue clear, beats every handshake
//   in_valid   in_instr carries an instruction
//   in_ready   an instruction can be accepted this cycle
//   in_instr   32-bit instruction word
//   out_valid  head entry valid
//   out_ready  consumer takes the head entry this cycle
//   out_imm    extended immediate of the head entry (0 when empty)
//   out_fmt    format of the head entry: 0 NONE, 1 D, 2 CB, 3 B, 4 I
//   count      number of occupied entries
module imm_gen_pipe #(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  out_imm,
  output logic [2:0]    out_fmt,
  output logic [CW-1:0] count
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);
  localparam logic [PW-1:0] LastPtr = PW'(DEPTH - 1);

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtD    = 3'd1,
    FmtCb   = 3'd2,
    FmtB    = 3'd3,
    FmtI    = 3'd4
  } fmt_e;

  // Combinational decode; the first matching format wins.
  logic [N-1:0] dec_imm;
  fmt_e         dec_fmt;

  always_comb begin
    dec_imm = '0;
    dec_fmt = FmtNone;
    if (in_instr[31:21] == 11'b11111000010 || in_instr[31:21] == 11'b11111000000) begin
      dec_fmt = FmtD;
      dec_imm = {{(N - 9){in_instr[20]}}, in_instr[20:12]};
    end else if (in_instr[31:24] == 8'b10110100 || in_instr[31:24] == 8'b10110101) begin
      dec_fmt = FmtCb;
      dec_imm = {{(N - 19){in_instr[23]}}, in_instr[23:5]};
    end else if (in_instr[31:26] == 6'b000101) begin
      dec_fmt = FmtB;
      dec_imm = {{(N - 26){in_instr[25]}}, in_instr[25:0]};
    end else if (in_instr[31:22] == 10'b1001000100 || in_instr[31:22] == 10'b1101000100) begin
      dec_fmt = FmtI;
      dec_imm = {{(N - 12){1'b0}}, in_instr[21:10]};
    end
  end

  // Queue state
  logic [N-1:0]  imm_mem [DEPTH];
  logic [2:0]    fmt_mem [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    // Explicit wrap so non-power-of-two depths work.
    if (p == LastPtr) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // in_ready depends only on registered state, flush and reset; never on out_ready.
  assign in_ready  = reset && !flush && (count_q < DepthC);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; outputs are masked to zero while empty instead.
  always_ff @(posedge clk) begin
    if (push) begin
      imm_mem[wr_ptr_q] <= dec_imm;
      fmt_mem[wr_ptr_q] <= dec_fmt;
    end
  end

  assign out_imm = out_valid ? imm_mem[rd_ptr_q] : '0;
  assign out_fmt = out_valid ? fmt_mem[rd_ptr_q] : 3'd0;
  assign count   = count_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three builds (N64/D2, N64/D3, N32/D2) share one
// stimulus stream and are checked every cycle against a queue model, plus
// hand-computed literal expectations.
module tb_imm_gen_pipe;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        out_ready;

  logic        rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
  logic [63:0] imm_a, imm_b;
  logic [31:0] imm_c;
  logic [2:0]  fmt_a, fmt_b, fmt_c;
  logic [1:0]  cnt_a, cnt_b, cnt_c;

  int tests;
  int fails;

  imm_gen_pipe #(.N(64), .DEPTH(2)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_a),
    .in_instr(in_instr), .out_valid(vld_a), .out_ready(out_ready), .out_imm(imm_a),
    .out_fmt(fmt_a), .count(cnt_a)
  );

  imm_gen_pipe #(.N(64), .DEPTH(3)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_b),
    .in_instr(in_instr), .out_valid(vld_b), .out_ready(out_ready), .out_imm(imm_b),
    .out_fmt(fmt_b), .count(cnt_b)
  );

  imm_gen_pipe #(.N(32), .DEPTH(2)) u_c (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(rdy_c),
    .in_instr(in_instr), .out_valid(vld_c), .out_ready(out_ready), .out_imm(imm_c),
    .out_fmt(fmt_c), .count(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode: {fmt, 64-bit immediate}; narrower builds take the low bits.
  function automatic logic [66:0] ref_dec(input logic [31:0] w);
    logic [63:0] v;
    logic [2:0]  f;
    logic [10:0] op11;
    logic [7:0]  op8;
    logic [9:0]  op10;
    op11 = w[31:21];
    op8  = w[31:24];
    op10 = w[31:22];
    v = '0;
    f = 3'd0;
    if (op11 == 11'h7C2 || op11 == 11'h7C0) begin
      f = 3'd1; v = 64'($signed(w[20:12]));
    end else if (op8 == 8'hB4 || op8 == 8'hB5) begin
      f = 3'd2; v = 64'($signed(w[23:5]));
    end else if (w[31:26] == 6'b000101) begin
      f = 3'd3; v = 64'($signed(w[25:0]));
    end else if (op10 == 10'b1001000100 || op10 == 10'b1101000100) begin
      f = 3'd4; v = 64'(w[21:10]);
    end
    return {f, v};
  endfunction

  function automatic logic [31:0] mk(input int i);
    case (i % 5)
      0:       return {11'h7C2, 9'(i * 37), 12'(i)};
      1:       return {8'hB5, 19'(i * 12345), 5'(i)};
      2:       return {6'b000101, 26'(i * 32'h0123457)};
      3:       return {10'b1101000100, 12'(i * 300), 10'(i)};
      default: return {8'h00, 24'(i)};
    endcase
  endfunction

  // Behavioural model: one queue per build.
  logic [66:0] qa[$];
  logic [66:0] qb[$];
  logic [66:0] qc[$];
  bit          ea, eb, ec, pa, pb, pc;
  logic [66:0] ent;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset || flush) begin
        qa.delete(); qb.delete(); qc.delete();
      end else begin
        pa = out_ready && qa.size() != 0;
        pb = out_ready && qb.size() != 0;
        pc = out_ready && qc.size() != 0;
        ea = in_valid && qa.size() < 2;
        eb = in_valid && qb.size() < 3;
        ec = in_valid && qc.size() < 2;
        ent = ref_dec(in_instr);
        if (pa) void'(qa.pop_front());
        if (pb) void'(qb.pop_front());
        if (pc) void'(qc.pop_front());
        if (ea) qa.push_back(ent);
        if (eb) qb.push_back(ent);
        if (ec) qc.push_back(ent);
      end
    end
  end

  task automatic cmp(input string nm, input logic v, input logic r, input logic [1:0] c,
                     input logic [63:0] imm, input logic [2:0] f, input int depth,
                     input bit n32, input int sz, input logic [66:0] hd);
    logic        ev, er;
    logic [63:0] ei;
    logic [2:0]  ef;
    ev = (sz != 0);
    er = reset && !flush && (sz < depth);
    ei = (sz == 0) ? 64'h0 : (n32 ? {32'h0, hd[31:0]} : hd[63:0]);
    ef = (sz == 0) ? 3'd0 : hd[66:64];
    tests++;
    if (v !== ev || r !== er || c !== 2'(sz) || imm !== ei || f !== ef) begin
      fails++;
      $display("FAIL %s t=%0t got v=%b r=%b cnt=%0d imm=%h fmt=%0d, want v=%b r=%b cnt=%0d imm=%h fmt=%0d",
               nm, $time, v, r, c, imm, f, ev, er, sz, ei, ef);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp("model_a", vld_a, rdy_a, cnt_a, imm_a, fmt_a, 2, 1'b0, qa.size(),
          qa.size() != 0 ? qa[0] : 67'h0);
      cmp("model_b", vld_b, rdy_b, cnt_b, imm_b, fmt_b, 3, 1'b0, qb.size(),
          qb.size() != 0 ? qb[0] : 67'h0);
      cmp("model_c", vld_c, rdy_c, cnt_c, {32'h0, imm_c}, fmt_c, 2, 1'b1, qc.size(),
          qc.size() != 0 ? qc[0] : 67'h0);
    end
  end

  task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s t=%0t got %h want %h", nm, $time, got, want);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] w, input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = w;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #2;
  endtask

  logic [31:0] vec  [7];
  logic [63:0] vimm [7];
  logic [2:0]  vfmt [7];

  initial begin
    vec[0] = {11'b11111000010, 9'b000001111, 12'h0};             vimm[0] = 64'h000000000000000F; vfmt[0] = 3'd1;
    vec[1] = {11'b11111000010, 9'b111110001, 12'h0};             vimm[1] = 64'hFFFFFFFFFFFFFFF1; vfmt[1] = 3'd1;
    vec[2] = {8'b10110100, 19'b0000000000000011111, 5'd0};        vimm[2] = 64'h000000000000001F; vfmt[2] = 3'd2;
    vec[3] = {8'b10110101, 19'b1111110000000011111, 5'd3};        vimm[3] = 64'hFFFFFFFFFFFFE01F; vfmt[3] = 3'd2;
    vec[4] = {6'b000101, 26'h3FFFFFF};                            vimm[4] = 64'hFFFFFFFFFFFFFFFF; vfmt[4] = 3'd3;
    vec[5] = {10'b1001000100, 12'hFFF, 10'h0};                    vimm[5] = 64'h0000000000000FFF; vfmt[5] = 3'd4;
    vec[6] = {8'b01110100, 24'h0};                                vimm[6] = 64'h0;                vfmt[6] = 3'd0;

    tests = 0; fails = 0;
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    lit("rst_in_ready", 64'(rdy_a), 64'h0);
    lit("rst_out_imm", imm_a, 64'h0);
    reset = 1'b1;
    #1;
    lit("rdy_after_rst", 64'(rdy_a), 64'h1);

    // Single vectors, one at a time
    for (int i = 0; i < 7; i++) begin
      step(1'b1, vec[i], 1'b1, 1'b0);
      lit($sformatf("vec%0d_imm", i), imm_a, vimm[i]);
      lit($sformatf("vec%0d_fmt", i), 64'(fmt_a), 64'(vfmt[i]));
      if (i == 3) lit("n32_cbnz", 64'(imm_c), 64'hFFFFE01F);
      step(1'b0, 32'h0, 1'b1, 1'b0);
    end

    // Backpressure on the depth-2 build
    step(1'b1, vec[0], 1'b0, 1'b0);
    step(1'b1, vec[1], 1'b0, 1'b0);
    step(1'b1, vec[4], 1'b0, 1'b0);
    lit("bp_count", 64'(cnt_a), 64'd2);
    lit("bp_in_ready", 64'(rdy_a), 64'd0);
    lit("bp_head", imm_a, vimm[0]);
    step(1'b1, vec[4], 1'b1, 1'b0);
    lit("bp_pop1_cnt", 64'(cnt_a), 64'd1);
    lit("bp_pop1_head", imm_a, vimm[1]);
    step(1'b1, vec[4], 1'b1, 1'b0);
    lit("bp_pop2_cnt", 64'(cnt_a), 64'd1);
    lit("bp_pop2_head", imm_a, vimm[4]);
    repeat (3) step(1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming through the depth-3 build
    for (int i = 0; i < 10; i++) begin
      step(1'b1, mk(i), 1'b1, 1'b0);
      tests++;
      if (cnt_b > 2'd1 || !vld_b) begin
        fails++;
        $display("FAIL stream%0d_count got cnt=%0d vld=%b want cnt<=1 vld=1", i, cnt_b, vld_b);
      end
      lit($sformatf("stream%0d_imm", i), imm_b, ref_dec(mk(i)) & 67'h0_FFFF_FFFF_FFFF_FFFF);
    end
    step(1'b0, 32'h0, 1'b1, 1'b0);
    lit("stream_drained", 64'(cnt_b), 64'd0);

    // Flush with a pending handshake on both sides
    step(1'b1, vec[0], 1'b0, 1'b0);
    step(1'b1, vec[1], 1'b0, 1'b0);
    lit("pre_flush_cnt", 64'(cnt_a), 64'd2);
    step(1'b1, vec[2], 1'b1, 1'b1);
    lit("flush_cnt", 64'(cnt_a), 64'd0);
    lit("flush_valid", 64'(vld_a), 64'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    lit("post_flush_cnt_b", 64'(cnt_b), 64'd0);

    // Asynchronous reset mid-stream
    step(1'b1, vec[5], 1'b0, 1'b0);
    step(1'b1, vec[6], 1'b0, 1'b0);
    in_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    lit("arst_valid", 64'(vld_a), 64'd0);
    lit("arst_imm", imm_a, 64'h0);
    lit("arst_cnt", 64'(cnt_a), 64'd0);
    lit("arst_in_ready", 64'(rdy_a), 64'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    step(1'b1, vec[3], 1'b1, 1'b0);
    lit("after_rst_imm", imm_a, vimm[3]);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
